taus88_reseed_ctrl: RTL and testbench

Reseed controller driving the `seed`/`re_seed` input side of a `taus88` generator and qualifying its `rnd` stream for downstream consumers. It accepts host seeds over a valid/ready handshake and optionally auto-reseeds after a programmable number of delivered words. It blanks the output stream while the generator settles, so consumers only ever see `rnd_valid` words drawn from a fully seeded state. It sits between the host/config fabric and the `taus88` instance.

---
 rtl/taus88_reseed_ctrl.sv | 147 ++++++++++++++
 tb/tb_taus88_reseed_ctrl.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/taus88_reseed_ctrl.sv
// Reseed controller for a taus88 generator.
//
// Accepts host seeds over a valid/ready handshake and can reseed the
// generator on its own after a programmable number of delivered words. After
// every re_seed pulse the rnd stream is blanked for SETTLE_CYCLES cycles, so
// rnd_valid words always come from a fully seeded generator state.
//
// Parameters:
//   SETTLE_CYCLES   blanking cycles after the re_seed pulse (legal 1..15)
//   AUTO_SEED_MASK  XOR mask applied to the current word to form auto seeds
//
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   host_seed          seed offered by the host
//   host_seed_valid    host seed offered
//   host_seed_ready    controller can take a host seed (IDLE or RUN)
//   auto_en            enable periodic auto-reseed
//   auto_period        valid words between auto-reseeds, 0 disables
//   rng_rnd            rnd word from the generator
//   seed, re_seed      drive the generator seed inputs
//   rnd_out            rng_rnd when rnd_valid, else 0 (combinational)
//   rnd_valid          rnd_out is a qualified word this cycle
//   busy               high while loading or settling
//   reseed_count       reseeds issued, saturating at 16'hFFFF

module taus88_reseed_ctrl #(
  parameter int unsigned SETTLE_CYCLES  = 2,
  parameter logic [31:0] AUTO_SEED_MASK = 32'h9E37_79B9
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] host_seed,
  input  logic        host_seed_valid,
  output logic        host_seed_ready,
  input  logic        auto_en,
  input  logic [15:0] auto_period,
  input  logic [31:0] rng_rnd,
  output logic [31:0] seed,
  output logic        re_seed,
  output logic [31:0] rnd_out,
  output logic        rnd_valid,
  output logic        busy,
  output logic [15:0] reseed_count
);

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StSettle,
    StRun
  } state_e;

  // Last count value of the settle window; the counter runs 0..SETTLE_CYCLES-1.
  localparam logic [3:0] SettleLast = 4'(SETTLE_CYCLES - 1);

  state_e      state_q, state_d;
  logic [31:0] seed_q, seed_d;
  logic [3:0]  settle_cnt_q, settle_cnt_d;
  logic [15:0] word_cnt_q, word_cnt_d;
  logic [15:0] reseed_count_q, reseed_count_d;

  logic        host_accept;
  logic        auto_fire;

  // Seeds 0 and 1 leave the Tausworthe components in degenerate states.
  function automatic logic [31:0] sanitize(input logic [31:0] s);
    return (s < 32'd2) ? 32'd2 : s;
  endfunction

  assign host_seed_ready = (state_q == StIdle) || (state_q == StRun);
  assign host_accept     = host_seed_valid && host_seed_ready;

  // Compared against the live period: shrinking it below the current count
  // fires on the next RUN cycle.
  assign auto_fire = (state_q == StRun) && auto_en && (auto_period != 16'd0) &&
                     (word_cnt_q >= (auto_period - 16'd1));

  always_comb begin
    state_d        = state_q;
    seed_d         = seed_q;
    settle_cnt_d   = settle_cnt_q;
    word_cnt_d     = word_cnt_q;
    reseed_count_d = reseed_count_q;

    case (state_q)
      StIdle, StRun: begin
        if ((state_q == StRun) && (word_cnt_q != 16'hFFFF)) begin
          word_cnt_d = word_cnt_q + 16'd1;
        end
        // Host seed has priority over a coincident auto trigger.
        if (host_accept) begin
          seed_d  = sanitize(host_seed);
          state_d = StLoad;
        end else if (auto_fire) begin
          seed_d  = sanitize(rng_rnd ^ AUTO_SEED_MASK);
          state_d = StLoad;
        end
      end
      StLoad: begin
        state_d      = StSettle;
        settle_cnt_d = 4'd0;
      end
      StSettle: begin
        if (settle_cnt_q == SettleLast) begin
          state_d = StRun;
        end else begin
          settle_cnt_d = settle_cnt_q + 4'd1;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // Entering LOAD: count the reseed and restart the word counter.
    if (state_d == StLoad) begin
      word_cnt_d = 16'd0;
      if (reseed_count_q != 16'hFFFF) begin
        reseed_count_d = reseed_count_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= StIdle;
      seed_q         <= 32'd0;
      settle_cnt_q   <= 4'd0;
      word_cnt_q     <= 16'd0;
      reseed_count_q <= 16'd0;
    end else begin
      state_q        <= state_d;
      seed_q         <= seed_d;
      settle_cnt_q   <= settle_cnt_d;
      word_cnt_q     <= word_cnt_d;
      reseed_count_q <= reseed_count_d;
    end
  end

  assign seed         = seed_q;
  assign re_seed      = (state_q == StLoad);
  assign busy         = (state_q == StLoad) || (state_q == StSettle);
  assign rnd_valid    = (state_q == StRun);
  assign rnd_out      = rnd_valid ? rng_rnd : 32'd0;
  assign reseed_count = reseed_count_q;

endmodule

// File: tb/tb_taus88_reseed_ctrl.sv
// Directed, table-driven bench for taus88_reseed_ctrl. Each table row is one
// clock cycle: inputs held for the cycle and the outputs expected during it.
// rng_rnd is driven by the bench with a known per-row value.

module tb_taus88_reseed_ctrl;

  localparam logic [31:0] Mask = 32'h9E37_79B9;
  localparam logic [31:0] Base = 32'h5A5A_0000;

  logic        clk;
  logic        rst_n;
  logic [31:0] host_seed;
  logic        host_seed_valid;
  logic        host_seed_ready;
  logic        auto_en;
  logic [15:0] auto_period;
  logic [31:0] rng_rnd;
  logic [31:0] seed;
  logic        re_seed;
  logic [31:0] rnd_out;
  logic        rnd_valid;
  logic        busy;
  logic [15:0] reseed_count;

  taus88_reseed_ctrl #(
    .SETTLE_CYCLES (2),
    .AUTO_SEED_MASK(Mask)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .host_seed      (host_seed),
    .host_seed_valid(host_seed_valid),
    .host_seed_ready(host_seed_ready),
    .auto_en        (auto_en),
    .auto_period    (auto_period),
    .rng_rnd        (rng_rnd),
    .seed           (seed),
    .re_seed        (re_seed),
    .rnd_out        (rnd_out),
    .rnd_valid      (rnd_valid),
    .busy           (busy),
    .reseed_count   (reseed_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        hv;
    logic [31:0] hs;
    logic        ae;
    logic [15:0] ap;
    logic [31:0] rng;
    logic        rdy;
    logic        rs;
    logic        bsy;
    logic        val;
    logic [31:0] sd;
    logic [15:0] cnt;
  } vec_t;

  vec_t vecs[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic add(input logic hv, input logic [31:0] hs, input logic ae,
                     input logic [15:0] ap, input logic rdy, input logic rs,
                     input logic bsy, input logic val, input logic [31:0] sd,
                     input logic [15:0] cnt);
    vec_t v;
    v.hv  = hv;
    v.hs  = hs;
    v.ae  = ae;
    v.ap  = ap;
    v.rng = Base + 32'(vecs.size());
    v.rdy = rdy;
    v.rs  = rs;
    v.bsy = bsy;
    v.val = val;
    v.sd  = sd;
    v.cnt = cnt;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at step %0d: got %h, expected %h", name, idx, act, exp);
    end
  endtask

  task automatic check_reset_state(input int idx);
    check("reset_ready", idx, 32'(host_seed_ready), 32'd1);
    check("reset_re_seed", idx, 32'(re_seed), 32'd0);
    check("reset_busy", idx, 32'(busy), 32'd0);
    check("reset_rnd_valid", idx, 32'(rnd_valid), 32'd0);
    check("reset_rnd_out", idx, rnd_out, 32'd0);
    check("reset_seed", idx, seed, 32'd0);
    check("reset_count", idx, 32'(reseed_count), 32'd0);
  endtask

  initial begin
    logic [31:0] d, c, a1, a2, h;
    d  = 32'hDEAD_BEEF;
    c  = 32'hCAFE_BABE;
    h  = 32'h1234_5678;
    a1 = (Base + 32'd13) ^ Mask;
    a2 = (Base + 32'd43) ^ Mask;

    // Rows: hv, hs, ae, ap | ready, re_seed, busy, rnd_valid, seed, count
    add(0, 0, 0, 0, 1, 0, 0, 0, 0, 0);                              // 0 idle
    add(1, d, 0, 0, 1, 0, 0, 0, 0, 0);                              // 1 accept
    add(0, 0, 0, 0, 0, 1, 1, 0, d, 1);                              // 2 load
    for (int i = 0; i < 2; i++) add(0, 0, 0, 0, 0, 0, 1, 0, d, 1);  // 3-4
    add(0, 0, 0, 0, 1, 0, 0, 1, d, 1);                              // 5 run
    add(1, c, 0, 0, 1, 0, 0, 1, d, 1);                              // 6 accept in run
    add(0, 0, 0, 0, 0, 1, 1, 0, c, 2);                              // 7
    for (int i = 0; i < 2; i++) add(0, 0, 0, 0, 0, 0, 1, 0, c, 2);  // 8-9
    for (int i = 0; i < 4; i++) add(0, 0, 1, 4, 1, 0, 0, 1, c, 2);  // 10-13 four words
    add(0, 0, 1, 4, 0, 1, 1, 0, a1, 3);                             // 14 auto load
    for (int i = 0; i < 2; i++) add(0, 0, 1, 4, 0, 0, 1, 0, a1, 3); // 15-16
    for (int i = 0; i < 4; i++) add(0, 0, 1, 4, 1, 0, 0, 1, a1, 3); // 17-20, 20 rng=mask
    add(0, 0, 1, 4, 0, 1, 1, 0, 2, 4);                              // 21 sanitised auto
    for (int i = 0; i < 2; i++) add(0, 0, 1, 4, 0, 0, 1, 0, 2, 4);  // 22-23
    for (int i = 0; i < 3; i++) add(0, 0, 1, 4, 1, 0, 0, 1, 2, 4);  // 24-26
    add(1, h, 1, 4, 1, 0, 0, 1, 2, 4);                              // 27 host + auto
    add(0, 0, 1, 4, 0, 1, 1, 0, h, 5);                              // 28 host wins
    for (int i = 0; i < 2; i++) add(1, 0, 1, 4, 0, 0, 1, 0, h, 5);  // 29-30 held valid
    add(1, 0, 1, 4, 1, 0, 0, 1, h, 5);                              // 31 accepted in run
    add(1, 1, 1, 4, 0, 1, 1, 0, 2, 6);                              // 32 seed 0 -> 2
    for (int i = 0; i < 2; i++) add(1, 1, 1, 4, 0, 0, 1, 0, 2, 6);  // 33-34
    add(1, 1, 0, 0, 1, 0, 0, 1, 2, 6);                              // 35 accept seed 1
    add(0, 0, 0, 0, 0, 1, 1, 0, 2, 7);                              // 36 seed 1 -> 2
    for (int i = 0; i < 2; i++) add(0, 0, 0, 0, 0, 0, 1, 0, 2, 7);  // 37-38
    add(0, 0, 0, 0, 1, 0, 0, 1, 2, 7);                              // 39 count 0
    for (int i = 0; i < 3; i++) add(0, 0, 1, 100, 1, 0, 0, 1, 2, 7); // 40-42
    add(0, 0, 1, 2, 1, 0, 0, 1, 2, 7);                              // 43 period lowered
    add(0, 0, 0, 0, 0, 1, 1, 0, a2, 8);                             // 44
    add(0, 0, 0, 0, 0, 0, 1, 0, a2, 8);                             // 45 settle
    vecs[20].rng = Mask;

    // Reset state.
    rst_n           = 1'b0;
    host_seed       = 32'd0;
    host_seed_valid = 1'b0;
    auto_en         = 1'b0;
    auto_period     = 16'd0;
    rng_rnd         = 32'hFFFF_0001;
    #2;
    check_reset_state(-1);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      @(posedge clk);
      #1;
      host_seed_valid = vecs[i].hv;
      host_seed       = vecs[i].hs;
      auto_en         = vecs[i].ae;
      auto_period     = vecs[i].ap;
      rng_rnd         = vecs[i].rng;
      #1;
      check("ready", i, 32'(host_seed_ready), 32'(vecs[i].rdy));
      check("re_seed", i, 32'(re_seed), 32'(vecs[i].rs));
      check("busy", i, 32'(busy), 32'(vecs[i].bsy));
      check("rnd_valid", i, 32'(rnd_valid), 32'(vecs[i].val));
      check("rnd_out", i, rnd_out, vecs[i].val ? vecs[i].rng : 32'd0);
      check("seed", i, seed, vecs[i].sd);
      check("reseed_count", i, 32'(reseed_count), 32'(vecs[i].cnt));
    end

    // Reset pulsed mid-SETTLE: outputs return immediately, FSM stays in IDLE.
    @(posedge clk);
    #1;
    host_seed_valid = 1'b0;
    auto_en         = 1'b1;
    auto_period     = 16'd1;
    rst_n           = 1'b0;
    #1;
    check_reset_state(100);
    #3;
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #2;
      check("post_reset_re_seed", 101 + i, 32'(re_seed), 32'd0);
      check("post_reset_valid", 101 + i, 32'(rnd_valid), 32'd0);
      check("post_reset_ready", 101 + i, 32'(host_seed_ready), 32'd1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
